fifo_stream_reader: RTL and testbench

//  Read-side drain engine for asynchronous_fifo. Sits in the rclk domain, pops the FIFO via
//  its r_en/empty/data_out port and presents words downstream on a valid/ready stream.
//  A 3-entry skid buffer absorbs the FIFO's 1-cycle read latency so that, with m_ready held high,
//  the block sustains one word per rclk. It also emits m_last every BURST_LEN beats and counts beats.

---
 rtl/fifo_stream_reader.sv | 93 +++++++++
 tb/tb_fifo_stream_reader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side drain engine: pops an asynchronous FIFO and streams the words out over valid/ready.
// A 3-entry skid buffer hides the FIFO's 1-cycle read latency; m_last marks burst ends.
module fifo_stream_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_r_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  words_out
);

  localparam int unsigned DEPTH = 3;
  localparam int unsigned BW    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] BURST_END = BW'(BURST_LEN - 1);

  logic [DATA_WIDTH-1:0] skid_q [DEPTH];
  logic [DATA_WIDTH-1:0] skid_n [DEPTH];
  logic [1:0]            occ_q, occ_n;
  logic                  inflight_q, inflight_n;
  logic [BW-1:0]         burst_q, burst_n;
  logic [CNT_WIDTH-1:0]  words_q, words_n;
  logic [2:0]            pending;
  logic                  xfer;
  logic [1:0]            wr_idx;

  // Pops are limited so buffered plus in-flight words never exceed the skid depth.
  always_comb begin
    pending   = 3'(occ_q) + 3'(inflight_q);
    fifo_r_en = !rrst && enable && !fifo_empty && (pending < 3'(DEPTH));
    m_valid   = (occ_q != 2'd0);
    m_data    = skid_q[0];
    m_last    = m_valid && (burst_q == BURST_END);
    words_out = words_q;
  end

  always_comb begin
    skid_n     = skid_q;
    occ_n      = occ_q;
    burst_n    = burst_q;
    words_n    = words_q;
    inflight_n = fifo_r_en;
    xfer       = m_valid && m_ready;
    wr_idx     = occ_q - {1'b0, xfer};

    if (xfer) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) begin
        skid_n[i] = skid_q[i + 1];
      end
      burst_n = (burst_q == BURST_END) ? '0 : burst_q + BW'(1);
      words_n = words_q + CNT_WIDTH'(1);
    end

    // Capture lands behind whatever remains after this cycle's transfer, keeping strict order.
    if (inflight_q) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wr_idx == 2'(i)) begin
          skid_n[i] = fifo_data;
        end
      end
    end

    occ_n = occ_q + {1'b0, inflight_q} - {1'b0, xfer};
  end

  // Reset discards buffered and in-flight words; the FIFO has already given them up.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      occ_q      <= '0;
      inflight_q <= 1'b0;
      burst_q    <= '0;
      words_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        skid_q[i] <= '0;
      end
    end else begin
      occ_q      <= occ_n;
      inflight_q <= inflight_n;
      burst_q    <= burst_n;
      words_q    <= words_n;
      skid_q     <= skid_n;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: FIFO model, queue-based reference, directed table and random phase.
module tb_fifo_stream_reader;

  localparam int BL = 8;

  logic       clk = 1'b0;
  logic       rrst, enable, fifo_empty, m_ready;
  logic [7:0] fifo_data;
  logic       fifo_r_en, m_valid, m_last;
  logic [7:0] m_data;
  logic [15:0] words_out;
  logic       fifo_r_en4, m_valid4, m_last4;
  logic [7:0] m_data4;
  logic [3:0] words_out4;

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_WIDTH(8), .BURST_LEN(BL), .CNT_WIDTH(16)) dut (
    .rclk(clk), .rrst(rrst), .enable(enable), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_r_en(fifo_r_en), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .words_out(words_out)
  );

  fifo_stream_reader #(.DATA_WIDTH(8), .BURST_LEN(BL), .CNT_WIDTH(4)) dut4 (
    .rclk(clk), .rrst(rrst), .enable(enable), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_r_en(fifo_r_en4), .m_data(m_data4), .m_valid(m_valid4), .m_ready(m_ready),
    .m_last(m_last4), .words_out(words_out4)
  );

  typedef struct { logic [7:0] data; int rdy; } pend_t;
  typedef struct {
    logic en; logic rdy; logic ren; logic vld; logic [7:0] data; logic last; int words;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int npop  = 0;
  int beats = 0;
  int burst_cnt = 0;
  logic model_ok = 1'b0;
  logic [15:0] exp_words = '0;

  logic [7:0] fq[$];
  pend_t      pend[$];
  logic [7:0] got[$];
  int         lastbeats[$];
  vec_t       tbl[11];
  logic [7:0] seq8 [8] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18};

  logic       s_ren, s_vld, s_last;
  logic [7:0] s_data;
  logic [15:0] s_words;
  logic [3:0] s_words4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [7:0] w);
    fq.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One rclk cycle: sample at negedge, compare with the reference, then advance model and FIFO.
  task automatic step();
    logic e_ren, e_vld, e_last;
    logic [7:0] pop_word;
    @(negedge clk);
    s_ren = fifo_r_en; s_vld = m_valid; s_data = m_data; s_last = m_last;
    s_words = words_out; s_words4 = words_out4;
    e_vld  = (pend.size() != 0) && (pend[0].rdy <= cyc);
    e_ren  = !rrst && enable && !fifo_empty && (pend.size() < 3);
    e_last = e_vld && (burst_cnt == BL - 1);
    if (model_ok) begin
      chk("fifo_r_en", 32'(s_ren), 32'(e_ren));
      chk("m_valid", 32'(s_vld), 32'(e_vld));
      chk("m_last", 32'(s_last), 32'(e_last));
      chk("words_out", 32'(s_words), 32'(exp_words));
      chk("fifo_r_en4", 32'(fifo_r_en4), 32'(e_ren));
      chk("m_valid4", 32'(m_valid4), 32'(e_vld));
      chk("m_last4", 32'(m_last4), 32'(e_last));
      chk("words_out4", 32'(s_words4), 32'(exp_words[3:0]));
      if (e_vld) begin
        chk("m_data", 32'(s_data), 32'(pend[0].data));
        chk("m_data4", 32'(m_data4), 32'(pend[0].data));
      end
    end
    if (s_ren) npop++;
    if (!rrst && s_vld && m_ready) begin
      got.push_back(s_data);
      beats++;
      if (s_last) lastbeats.push_back(beats);
    end
    pop_word = (fq.size() != 0) ? fq[0] : 8'h00;
    @(posedge clk);
    #1;
    if (rrst) begin
      pend.delete();
      burst_cnt = 0;
      exp_words = '0;
      model_ok  = 1'b1;
    end else if (model_ok) begin
      if (e_vld && m_ready) begin
        void'(pend.pop_front());
        burst_cnt = (burst_cnt + 1) % BL;
        exp_words = exp_words + 16'd1;
      end
      if (e_ren) pend.push_back('{data: pop_word, rdy: cyc + 2});
    end
    if (s_ren) begin
      if (fq.size() == 0) begin
        total++; bad++;
        $display("FAIL pop_while_empty: got r_en=1 expected 0 (cycle %0d)", cyc);
      end else begin
        fifo_data = fq.pop_front();
      end
    end
    fifo_empty = (fq.size() == 0);
    cyc++;
  endtask

  task automatic run_until(input int n, input int budget);
    for (int i = 0; i < budget && got.size() < n; i++) step();
    chk("delivered_count", 32'(got.size()), 32'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Test 2 expectations, one row per cycle after the 8 words are loaded.
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hA1, 1'b0, 0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hB2, 1'b0, 1};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hC3, 1'b0, 2};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hD4, 1'b0, 3};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hE5, 1'b0, 4};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hF6, 1'b0, 5};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h07, 1'b0, 6};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h18, 1'b1, 7};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8};

    rrst = 1'b1; enable = 1'b1; fifo_empty = 1'b1; fifo_data = 8'h00; m_ready = 1'b1;

    // Test 1: reset with an empty FIFO
    step(); step();
    rrst = 1'b0;
    npop = 0;
    for (int i = 0; i < 3; i++) step();
    chk("t1_pops", 32'(npop), 32'd0);
    chk("t1_valid", 32'(s_vld), 32'd0);
    chk("t1_mdata", 32'(s_data), 32'd0);
    chk("t1_words", 32'(s_words), 32'd0);

    // Test 2: back-to-back drain, table-driven
    for (int i = 0; i < 8; i++) push(seq8[i]);
    for (int i = 0; i < 11; i++) begin
      enable = tbl[i].en;
      m_ready = tbl[i].rdy;
      step();
      chk("t2_ren", 32'(s_ren), 32'(tbl[i].ren));
      chk("t2_valid", 32'(s_vld), 32'(tbl[i].vld));
      chk("t2_last", 32'(s_last), 32'(tbl[i].last));
      chk("t2_words", 32'(s_words), 32'(tbl[i].words));
      if (tbl[i].vld) chk("t2_data", 32'(s_data), 32'(tbl[i].data));
    end

    // Test 3: stalled sink fills the skid buffer with exactly three pops
    m_ready = 1'b0; npop = 0;
    for (int i = 0; i < 8; i++) push(seq8[i]);
    for (int i = 0; i < 8; i++) step();
    chk("t3_pops", 32'(npop), 32'd3);
    chk("t3_hold_valid", 32'(s_vld), 32'd1);
    chk("t3_hold_data", 32'(s_data), 32'hA1);
    m_ready = 1'b1; got.delete();
    run_until(8, 40);
    for (int i = 0; i < 8; i++)
      chk("t3_order", 32'((got.size() > i) ? got[i] : 8'h00), 32'(seq8[i]));

    // Test 4: enable drops after the second pop
    for (int i = 0; i < 4; i++) step();
    npop = 0; got.delete();
    for (int i = 0; i < 8; i++) push(seq8[i]);
    step(); step();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("t4_pops", 32'(npop), 32'd2);
    chk("t4_count", 32'(got.size()), 32'd2);
    enable = 1'b1;
    run_until(8, 40);
    for (int i = 0; i < 8; i++)
      chk("t4_order", 32'((got.size() > i) ? got[i] : 8'h00), 32'(seq8[i]));

    // Test 5: reset with three words buffered, after one beat moved the burst position
    for (int i = 0; i < 4; i++) step();
    got.delete();
    push(8'h55);
    run_until(1, 10);
    m_ready = 1'b0;
    push(8'h11); push(8'h22); push(8'h33);
    for (int i = 0; i < 6; i++) step();
    chk("t5_full_valid", 32'(s_vld), 32'd1);
    rrst = 1'b1; step();
    rrst = 1'b0; step();
    chk("t5_valid_after_rst", 32'(s_vld), 32'd0);
    chk("t5_words_after_rst", 32'(s_words), 32'd0);
    m_ready = 1'b1; got.delete(); beats = 0; lastbeats.delete();
    push(8'hAA); push(8'hBB);
    for (int i = 1; i <= 6; i++) push(8'(i));
    run_until(8, 40);
    chk("t5_first", 32'((got.size() > 0) ? got[0] : 8'h00), 32'hAA);
    chk("t5_second", 32'((got.size() > 1) ? got[1] : 8'h00), 32'hBB);
    chk("t5_last_count", 32'(lastbeats.size()), 32'd1);
    chk("t5_last_beat", 32'((lastbeats.size() > 0) ? lastbeats[0] : -1), 32'd8);

    // Test 6: 17 beats, 4-bit counter wraps
    rrst = 1'b1; step();
    rrst = 1'b0;
    beats = 0; lastbeats.delete(); got.delete();
    for (int i = 0; i < 17; i++) push(8'(8'h40 + i));
    run_until(17, 60);
    step(); step();
    chk("t6_words4", 32'(s_words4), 32'd1);
    chk("t6_words16", 32'(s_words), 32'd17);
    chk("t6_last_count", 32'(lastbeats.size()), 32'd2);
    chk("t6_last_a", 32'((lastbeats.size() > 0) ? lastbeats[0] : -1), 32'd8);
    chk("t6_last_b", 32'((lastbeats.size() > 1) ? lastbeats[1] : -1), 32'd16);

    // Random phase against the reference model
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 2) == 0 && fq.size() < 16) push(8'($urandom));
      enable  = ($urandom_range(0, 7) != 0);
      m_ready = ((i / 256) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rrst    = ($urandom_range(0, 149) == 0);
      step();
    end
    rrst = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
